perf_counter_sampler: RTL and testbench
=======================================

PERF_COUNTER_SAMPLER -- requirements
Module: perf_counter_sampler

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, cycles from read issue to avm_readdata valid (1..4).
REQ-002 SHALL have parameter MAX_RETRY, default 3, maximum re-reads on a torn 64-bit sample (0..7).
REQ-003 SHALL have clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have cmd_valid  input  1  command request.
REQ-006 SHALL have cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have cmd_op  input  2  0=STOP, 1=START, 2=CLEAR, 3=SAMPLE.
REQ-008 SHALL have cmd_sel  input  1  counter section (0 or 1).
REQ-009 SHALL have res_valid  output  1  one-cycle pulse, SAMPLE result ready.
REQ-010 SHALL have res_time  output  64  sampled time counter.
REQ-011 SHALL have res_events  output  32  sampled event counter.
REQ-012 SHALL have res_torn  output  1  high with res_valid if no coherent sample within MAX_RETRY.
REQ-013 SHALL have avm_address  output  3  counter-slave word address.
REQ-014 SHALL have avm_write, avm_read, avm_begintransfer  output  1 each  bus strobes.
REQ-015 SHALL have avm_writedata  output  32  write data.
REQ-016 SHALL have avm_readdata  input  32  read data from counter slave.

Function
REQ-017 Section base address SHALL be cmd_sel*4; offsets: +0 time lo / stop, +1 time hi / go, +2 events.
REQ-018 cmd_ready SHALL be high only in IDLE; command fields SHALL be latched on acceptance.
REQ-019 STOP SHALL issue one write cycle: address base+0, writedata 0.
REQ-020 START SHALL issue one write cycle: address base+1, writedata 0.
REQ-021 CLEAR SHALL issue one write cycle: address 0, writedata 1, cmd_sel ignored.
REQ-022 Every bus cycle SHALL assert avm_begintransfer together with exactly one of avm_write/avm_read for exactly one clk.
REQ-023 Write commands SHALL return to IDLE the cycle after the write cycle; cmd_ready high again 2 cycles after acceptance.
REQ-024 SAMPLE SHALL read in order: HI0 (base+1), LO (base+0), HI1 (base+1), EV (base+2).
REQ-025 Each read SHALL be followed by a WAIT state of READ_LATENCY cycles; avm_readdata SHALL be captured on the last WAIT cycle.
REQ-026 If HI1==HI0, result SHALL be {HI1,LO}; else retry from LO with HI0:=HI1, counting retries.
REQ-027 When retry count reaches MAX_RETRY with HI mismatch, result SHALL be {HI1,LO} with res_torn=1.
REQ-028 After EV capture, res_valid SHALL pulse for one cycle with res_time/res_events/res_torn; FSM returns to IDLE.
REQ-029 res_time, res_events, res_torn SHALL hold until the next res_valid.
REQ-030 States: IDLE, WRITE, RD_HI0, RD_LO, RD_HI1, RD_EV, WAIT, DONE; WAIT returns to state after the issuing read.
REQ-031 Bus outputs SHALL be 0 (address 0, strobes low, writedata 0) in all non-issuing states.
REQ-032 Coherent SAMPLE latency, READ_LATENCY=1: res_valid 9 cycles after acceptance.

Reset
REQ-033 On reset_n low: state IDLE, cmd_ready 1 after release, res_valid 0, res_time 0, res_events 0, res_torn 0, all bus strobes 0, retry count 0.
REQ-034 Reset mid-transaction SHALL abort immediately with no res_valid pulse.

Structure
REQ-035 Opcode encodings, offset constants (STOP/GO/EVT) and state encoding SHALL reside in a shared package perf_counter_pkg.
REQ-036 A single sub-module perf_bus_issuer (one-cycle strobe generator plus latency wait counter) is natural.

Verification
REQ-037 START sel=1 -> one cycle avm_address=5, avm_write=1, avm_begintransfer=1, writedata 0.
REQ-038 CLEAR sel=1 -> avm_address=0, writedata=1; counter slave time/event counters read 0 afterwards.
REQ-039 SAMPLE on stopped section 0 holding time 0x00000002_FFFFFFF0, events 7 -> res_time 0x00000002_FFFFFFF0, res_events 7, res_torn 0, res_valid at cycle 9.
REQ-040 SAMPLE on running counter with LO near 0xFFFFFFFF -> one retry, coherent res_time, res_torn 0.
REQ-041 Model forcing HI change every read, MAX_RETRY=3 -> 4 LO reads, res_torn 1.
REQ-042 reset_n low during RD_LO WAIT -> strobes 0, no res_valid, cmd_ready 1 after release.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Shared definitions for the performance-counter sampler: command opcodes,
// counter-slave register offsets, FSM state encoding and an address helper.
package perf_counter_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_STOP   = 2'd0,
    OP_START  = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_SAMPLE = 2'd3
  } op_e;

  // Word offsets inside one counter section (section base = sel*4).
  // Offset 0 is the time-low word on reads and the stop register on writes;
  // offset 1 is the time-high word on reads and the go register on writes.
  localparam logic [1:0] OFF_STOP = 2'd0;
  localparam logic [1:0] OFF_GO   = 2'd1;
  localparam logic [1:0] OFF_EVT  = 2'd2;

  // CLEAR is a global command: fixed address and data, section ignored.
  localparam logic [2:0]  CLEAR_ADDR = 3'd0;
  localparam logic [31:0] CLEAR_DATA = 32'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_RD_HI0 = 3'd2,
    S_RD_LO  = 3'd3,
    S_RD_HI1 = 3'd4,
    S_RD_EV  = 3'd5,
    S_WAIT   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Word address of a register within a counter section.
  function automatic logic [2:0] sec_addr(input logic sel, input logic [1:0] off);
    return {sel, off};
  endfunction

endpackage

// File: rtl/perf_bus_issuer.sv
// Bus-cycle issuer: turns a one-cycle issue request into the strobes of a
// single bus cycle and times the read latency that follows it.
module perf_bus_issuer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_wr,
  input  logic        issue_rd,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  output logic        wait_done
);

  logic [2:0] wait_cnt;

  // Strobes decode straight from the caller's registered state, so each bus
  // cycle lasts exactly one clock and everything is zero between cycles.
  always_comb begin
    avm_write         = issue_wr;
    avm_read          = issue_rd;
    avm_begintransfer = issue_wr | issue_rd;
    avm_address       = (issue_wr | issue_rd) ? addr : 3'd0;
    avm_writedata     = issue_wr ? wdata : 32'd0;
  end

  // Load the latency on a read and count down; the last wait cycle is the one
  // where the counter slave presents avm_readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 3'd0;
    end else if (issue_rd) begin
      wait_cnt <= 3'(READ_LATENCY);
    end else if (wait_cnt != 3'd0) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  assign wait_done = (wait_cnt == 3'd1);

endmodule

// File: rtl/perf_counter_sampler.sv
// Performance-counter sampler: accepts STOP/START/CLEAR/SAMPLE commands and
// drives a counter slave over a simple bus. SAMPLE reads the 64-bit time
// counter as HI, LO, HI and retries on a carry between the halves, then reads
// the event counter and reports the result with a one-cycle res_valid pulse.
module perf_counter_sampler
  import perf_counter_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_sel,
  output logic        res_valid,
  output logic [63:0] res_time,
  output logic [31:0] res_events,
  output logic        res_torn,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  state_e      state;
  state_e      rd_state;   // read that launched the current WAIT
  op_e         op_q;
  logic        sel_q;
  logic [31:0] hi0_q;
  logic [31:0] lo_q;
  logic [2:0]  retry_q;
  logic [63:0] time_q;
  logic        torn_q;

  logic        issue_wr;
  logic        issue_rd;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        wait_done;

  assign cmd_ready = (state == S_IDLE);

  // Address and data for the bus cycle owned by the current issuing state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 32'd0;
    case (state)
      S_WRITE: begin
        issue_wr = 1'b1;
        if (op_q == OP_CLEAR) begin
          bus_addr  = CLEAR_ADDR;
          bus_wdata = CLEAR_DATA;
        end else begin
          bus_addr = sec_addr(sel_q, (op_q == OP_STOP) ? OFF_STOP : OFF_GO);
        end
      end
      S_RD_HI0, S_RD_HI1: begin
        issue_rd = 1'b1;
        bus_addr = sec_addr(sel_q, OFF_GO);
      end
      S_RD_LO: begin
        issue_rd = 1'b1;
        bus_addr = sec_addr(sel_q, OFF_STOP);
      end
      S_RD_EV: begin
        issue_rd = 1'b1;
        bus_addr = sec_addr(sel_q, OFF_EVT);
      end
      default: ;
    endcase
  end

  perf_bus_issuer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_issuer (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_wr          (issue_wr),
    .issue_rd          (issue_rd),
    .addr              (bus_addr),
    .wdata             (bus_wdata),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata),
    .wait_done         (wait_done)
  );

  // Command FSM: latches the command, sequences the reads with carry retry,
  // and publishes the result registers together with res_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the asynchronous reset clears every register here, including the
    // result outputs, so a reset mid-SAMPLE leaves nothing half-published.
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_state   <= S_IDLE;
      op_q       <= OP_STOP;
      sel_q      <= 1'b0;
      hi0_q      <= 32'd0;
      lo_q       <= 32'd0;
      retry_q    <= 3'd0;
      time_q     <= 64'd0;
      torn_q     <= 1'b0;
      res_valid  <= 1'b0;
      res_time   <= 64'd0;
      res_events <= 32'd0;
      res_torn   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register updates
      // from the values of the previous cycle regardless of statement order.
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            sel_q   <= cmd_sel;
            retry_q <= 3'd0;
            state   <= (op_e'(cmd_op) == OP_SAMPLE) ? S_RD_HI0 : S_WRITE;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_RD_HI0, S_RD_LO, S_RD_HI1, S_RD_EV: begin
          rd_state <= state;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_done) begin
            case (rd_state)
              S_RD_HI0: begin
                hi0_q <= avm_readdata;
                state <= S_RD_LO;
              end
              S_RD_LO: begin
                lo_q  <= avm_readdata;
                state <= S_RD_HI1;
              end
              S_RD_HI1: begin
                // Matching high words bracket a coherent low word; once the
                // retry budget is spent, report the last pair as torn.
                if ((avm_readdata == hi0_q) || (retry_q == 3'(MAX_RETRY))) begin
                  time_q <= {avm_readdata, lo_q};
                  torn_q <= (avm_readdata != hi0_q);
                  state  <= S_RD_EV;
                end else begin
                  hi0_q   <= avm_readdata;
                  retry_q <= retry_q + 3'd1;
                  state   <= S_RD_LO;
                end
              end
              S_RD_EV: begin
                res_valid  <= 1'b1;
                res_time   <= time_q;
                res_events <= avm_readdata;
                res_torn   <= torn_q;
                state      <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Scoreboard bench for perf_counter_sampler with a behavioural counter slave.
// Stimulus pushes expected results and writes into queues; monitors on the
// falling edge pop and compare whenever the DUT presents them.
module tb_perf_counter_sampler;

  localparam int READ_LATENCY = 1;
  localparam int MAX_RETRY    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_sel = 1'b0;
  logic        res_valid;
  logic [63:0] res_time;
  logic [31:0] res_events;
  logic        res_torn;
  logic [2:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic        avm_begintransfer;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  perf_counter_sampler #(
    .READ_LATENCY(READ_LATENCY),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_sel           (cmd_sel),
    .res_valid         (res_valid),
    .res_time          (res_time),
    .res_events        (res_events),
    .res_torn          (res_torn),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- counter slave model ----------------
  // Time advances by 4 on every read of a running section, so carries land
  // at predictable points of the read sequence. In jitter mode every high-word
  // read returns a fresh value.
  logic [63:0] m_time [2] = '{64'd0, 64'd0};
  logic [31:0] m_ev   [2] = '{32'd0, 32'd0};
  logic        m_run  [2] = '{1'b0, 1'b0};
  logic        m_jit = 1'b0;
  logic [31:0] m_jit_hi = 32'd0;
  int          m_lo_reads = 0;
  logic [31:0] rd_q = 32'd0;

  logic        ld_req = 1'b0;
  logic        ld_sel = 1'b0;
  logic        ld_jit = 1'b0;
  logic [63:0] ld_time = 64'd0;
  logic [31:0] ld_ev = 32'd0;
  logic [31:0] ld_jit_hi = 32'd0;

  assign avm_readdata = rd_q;

  always @(posedge clk) begin
    if (ld_req) begin
      m_time[ld_sel] <= ld_time;
      m_ev[ld_sel]   <= ld_ev;
      m_jit          <= ld_jit;
      m_jit_hi       <= ld_jit_hi;
    end
    if (avm_write) begin
      if (avm_address == 3'd0 && avm_writedata == 32'd1) begin
        m_time[0] <= 64'd0;
        m_time[1] <= 64'd0;
        m_ev[0]   <= 32'd0;
        m_ev[1]   <= 32'd0;
      end else if (avm_address[1:0] == 2'd0) begin
        m_run[avm_address[2]] <= 1'b0;
      end else if (avm_address[1:0] == 2'd1) begin
        m_run[avm_address[2]] <= 1'b1;
      end
    end
    if (avm_read) begin
      case (avm_address[1:0])
        2'd0: begin
          rd_q       <= m_time[avm_address[2]][31:0];
          m_lo_reads <= m_lo_reads + 1;
        end
        2'd1: begin
          if (m_jit) begin
            rd_q     <= m_jit_hi;
            m_jit_hi <= m_jit_hi + 32'd1;
          end else begin
            rd_q <= m_time[avm_address[2]][63:32];
          end
        end
        2'd2:    rd_q <= m_ev[avm_address[2]];
        default: rd_q <= 32'hDEAD_BEEF;
      endcase
      if (m_run[avm_address[2]]) m_time[avm_address[2]] <= m_time[avm_address[2]] + 64'd4;
    end
  end

  // ---------------- scoreboards and monitors ----------------
  typedef struct {
    logic [63:0] t;
    logic [31:0] e;
    logic        torn;
    int          acc;
    int          lat;
  } exp_res_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          at;
  } exp_wr_t;

  exp_res_t exp_q[$];
  exp_wr_t  wr_q[$];
  int       rv_count = 0;

  // Bus monitor: strobe shape, idle zeros, and expected write cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_begintransfer || avm_write || avm_read) begin
        check("strobe_shape", 64'(avm_begintransfer && (avm_write ^ avm_read)), 64'd1);
      end else begin
        check("idle_bus_zero", {29'd0, avm_address, avm_writedata}, 64'd0);
      end
      if (avm_write) begin
        check("write_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          exp_wr_t w;
          w = wr_q.pop_front();
          check("write_addr", 64'(avm_address), 64'(w.addr));
          check("write_data", 64'(avm_writedata), 64'(w.data));
          check("write_cycle", 64'(cyc), 64'(w.at));
        end
      end
    end
  end

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && res_valid) begin
      rv_count++;
      check("res_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_res_t x;
        x = exp_q.pop_front();
        check("res_time", res_time, x.t);
        check("res_events", 64'(res_events), 64'(x.e));
        check("res_torn", 64'(res_torn), 64'(x.torn));
        check("res_latency", 64'(cyc - x.acc), 64'(x.lat));
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic model_load(input logic sel, input logic [63:0] t, input logic [31:0] e,
                            input logic jit, input logic [31:0] jit_hi);
    @(negedge clk);
    ld_sel = sel; ld_time = t; ld_ev = e; ld_jit = jit; ld_jit_hi = jit_hi; ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Drives a command at a falling edge once ready; returns at the accepting
  // rising edge with acc set to the acceptance cycle number.
  task automatic do_cmd(input logic [1:0] op, input logic sel, output int acc);
    int budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    acc       = cyc;
    @(posedge clk);
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && cmd_ready;
    end
    check("drain", 64'(done), 64'd1);
  endtask

  task automatic do_write(input logic [1:0] op, input logic sel,
                          input logic [2:0] addr, input logic [31:0] data);
    int acc;
    do_cmd(op, sel, acc);
    wr_q.push_back('{addr: addr, data: data, at: acc + 1});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ready_low_in_write", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready_back_after_write", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_sample(input logic sel, input logic [63:0] t, input logic [31:0] e,
                           input logic torn, input int lat);
    int acc;
    do_cmd(2'd3, sel, acc);
    exp_q.push_back('{t: t, e: e, torn: torn, acc: acc, lat: lat});
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lo_before;
    int rv_before;
    int acc;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_time", res_time, 64'd0);
    check("rst_res_events", 64'(res_events), 64'd0);
    check("rst_res_torn", 64'(res_torn), 64'd0);
    check("rst_strobes", 64'({avm_begintransfer, avm_write, avm_read}), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);

    // Stopped section 0: coherent sample, 9-cycle latency.
    model_load(1'b0, 64'h0000_0002_FFFF_FFF0, 32'd7, 1'b0, 32'd0);
    lo_before = m_lo_reads;
    do_sample(1'b0, 64'h0000_0002_FFFF_FFF0, 32'd7, 1'b0, 9);
    check("lo_reads_coherent", 64'(m_lo_reads - lo_before), 64'd1);

    // START / STOP on section 1.
    do_write(2'd1, 1'b1, 3'd5, 32'd0);
    check("run1_after_start", 64'(m_run[1]), 64'd1);
    do_write(2'd0, 1'b1, 3'd4, 32'd0);
    check("run1_after_stop", 64'(m_run[1]), 64'd0);

    // Running section 1 with the low word about to wrap: exactly one retry.
    model_load(1'b1, 64'h0000_0004_FFFF_FFF8, 32'h55, 1'b0, 32'd0);
    do_write(2'd1, 1'b1, 3'd5, 32'd0);
    lo_before = m_lo_reads;
    do_sample(1'b1, 64'h0000_0005_0000_0004, 32'h55, 1'b0, 13);
    check("lo_reads_one_retry", 64'(m_lo_reads - lo_before), 64'd2);
    do_write(2'd0, 1'b1, 3'd4, 32'd0);

    // High word changes on every read: retries exhausted, torn result.
    model_load(1'b0, 64'h0000_0000_0000_1234, 32'd7, 1'b1, 32'h10);
    lo_before = m_lo_reads;
    do_sample(1'b0, 64'h0000_0014_0000_1234, 32'd7, 1'b1, 21);
    check("lo_reads_torn", 64'(m_lo_reads - lo_before), 64'd4);
    repeat (5) @(negedge clk);
    check("hold_res_time", res_time, 64'h0000_0014_0000_1234);
    check("hold_res_torn", 64'(res_torn), 64'd1);
    check("hold_res_valid_low", 64'(res_valid), 64'd0);

    // CLEAR with sel=1 still targets address 0 and clears both sections.
    model_load(1'b0, 64'h0000_0009_0000_0009, 32'd3, 1'b0, 32'd0);
    do_write(2'd2, 1'b1, 3'd0, 32'd1);
    do_sample(1'b0, 64'd0, 32'd0, 1'b0, 9);
    do_sample(1'b1, 64'd0, 32'd0, 1'b0, 9);

    // STOP on section 0 shares address 0 with CLEAR but carries data 0.
    do_write(2'd0, 1'b0, 3'd0, 32'd0);

    // Reset in the wait after the LO read: abort with no result.
    rv_before = rv_count;
    do_cmd(2'd3, 1'b0, acc);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_hi0_read", 64'(avm_read), 64'd1);
    check("abort_hi0_addr", 64'(avm_address), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort_lo_read", 64'(avm_read), 64'd1);
    check("abort_lo_addr", 64'(avm_address), 64'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_strobes", 64'({avm_begintransfer, avm_write, avm_read}), 64'd0);
    check("abort_res_valid", 64'(res_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_pulse", 64'(rv_count - rv_before), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    check("abort_res_time", res_time, 64'd0);

    // Normal operation after the aborted transaction.
    do_sample(1'b0, 64'd0, 32'd0, 1'b0, 9);

    check("res_queue_empty", 64'(exp_q.size()), 64'd0);
    check("write_queue_empty", 64'(wr_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
